// File: rtl/eddy_current_sample_scheduler_if.sv
// SPI master link of the eddy-current sample scheduler: enable level out,
// data_ready and the captured X/Y sensor words back.
interface eddy_current_sample_scheduler_if #(
    parameter int DATA_W = 18
);
    logic                     spi_en;
    logic                     spi_data_ready;
    logic signed [DATA_W-1:0] spi_data_x;
    logic signed [DATA_W-1:0] spi_data_y;

    modport master (
        output spi_en,
        input  spi_data_ready,
        input  spi_data_x,
        input  spi_data_y
    );

    modport slave (
        input  spi_en,
        output spi_data_ready,
        output spi_data_x,
        output spi_data_y
    );
endinterface

// File: rtl/eddy_current_sample_scheduler.sv
// Triggers SPI conversion bursts, averages 2^avg_log2 X/Y samples and emits one result per trigger.
// Optional result counter: define ECS_SAMPLE_COUNTER_EN to build sample_count.
module eddy_current_sample_scheduler #(
    parameter int DATA_W         = 18,
    parameter int TIMER_W        = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     mode,
    input  logic [TIMER_W-1:0]       period,
    input  logic [1:0]               avg_log2,
    input  logic                     sync_trig,
    input  logic                     clr_err,
    eddy_current_sample_scheduler_if.master spi,
    output logic signed [DATA_W-1:0] out_x,
    output logic signed [DATA_W-1:0] out_y,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun,
    output logic                     timeout_err,
    output logic [15:0]              sample_count
);

    localparam int ACC_W = DATA_W + 3;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_RX,
        WAIT_DONE,
        OUTPUT
    } state_t;

    state_t state, state_n;

    logic                    sync_q, sync_q2, ext_trig;
    logic [TIMER_W-1:0]      timer;
    logic                    tmr_hit, trig, accept;
    logic [1:0]              log_q;
    logic [3:0]              idx;
    logic signed [ACC_W-1:0] acc_x, acc_y;
    logic [TMO_W-1:0]        tmo_cnt;
    logic                    flush;
    logic                    in_wait, tmo_hit, done, take, last;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    function automatic logic signed [DATA_W-1:0] avg_shift(input logic signed [ACC_W-1:0] acc,
                                                           input logic [1:0] sh);
        return DATA_W'(acc >>> sh);
    endfunction

    // A period shrunk below the running count wraps on the next cycle
    assign tmr_hit = (period != '0) && (timer >= period - TIMER_W'(1));
    assign trig    = enable && (mode ? ext_trig : tmr_hit);
    assign accept  = (state == ARM) && trig;
    assign in_wait = (state == WAIT_RX) || (state == WAIT_DONE);
    assign tmo_hit = in_wait && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign done    = (state == WAIT_DONE) && spi.spi_data_ready;
    assign take    = done && !flush && !tmo_hit;
    assign last    = (idx + 4'd1) == (4'd1 << log_q);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (enable) state_n = ARM;
            ARM:       if (trig) state_n = WAIT_RX;
            WAIT_RX: begin
                if (tmo_hit)                  state_n = ARM;
                else if (!spi.spi_data_ready) state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tmo_hit)   state_n = ARM;
                else if (done) state_n = (!flush && last) ? OUTPUT : WAIT_RX;
            end
            OUTPUT:    state_n = ARM;
            default:   state_n = IDLE;
        endcase
        if (!enable) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sync_q      <= 1'b0;
            sync_q2     <= 1'b0;
            ext_trig    <= 1'b0;
            timer       <= '0;
            log_q       <= '0;
            idx         <= '0;
            acc_x       <= '0;
            acc_y       <= '0;
            tmo_cnt     <= '0;
            flush       <= 1'b1;
            spi.spi_en  <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            out_valid   <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
        end else begin
            state    <= state_n;
            sync_q   <= sync_trig;
            sync_q2  <= sync_q;
            ext_trig <= sync_q & ~sync_q2;

            if (!enable || period == '0) timer <= '0;
            else if (tmr_hit)            timer <= '0;
            else                         timer <= timer + TIMER_W'(1);

            spi.spi_en <= (state_n == WAIT_RX) || (state_n == WAIT_DONE);
            busy       <= (state_n == WAIT_RX) || (state_n == WAIT_DONE) || (state_n == OUTPUT);
            overrun    <= trig && (state != ARM);

            if (tmo_hit)      timeout_err <= 1'b1;
            else if (clr_err) timeout_err <= 1'b0;

            // Any abort leaves the master possibly mid-frame, so its next word is untrusted
            if (tmo_hit || !enable)  flush <= 1'b1;
            else if (done && flush)  flush <= 1'b0;

            if (state_n == WAIT_RX && state != WAIT_RX) tmo_cnt <= '0;
            else if (in_wait)                           tmo_cnt <= tmo_cnt + TMO_W'(1);

            if (accept) begin
                log_q <= avg_log2;
                idx   <= '0;
                acc_x <= '0;
                acc_y <= '0;
            end else if (take) begin
                idx   <= idx + 4'd1;
                acc_x <= acc_x + sext(spi.spi_data_x);
                acc_y <= acc_y + sext(spi.spi_data_y);
            end

            // Result stage: registered average, strobed once per burst
            if (state == OUTPUT && enable) begin
                out_x     <= avg_shift(acc_x, log_q);
                out_y     <= avg_shift(acc_y, log_q);
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ECS_SAMPLE_COUNTER_EN
    always_ff @(posedge clk) begin
        if (rst)            sample_count <= '0;
        else if (out_valid) sample_count <= sample_count + 16'd1;
    end
`else
    assign sample_count = '0;
`endif

endmodule

// File: tb/tb_eddy_current_sample_scheduler.sv
// Directed bench for eddy_current_sample_scheduler with a simple SPI master model.
module tb_eddy_current_sample_scheduler;

    localparam int DATA_W  = 18;
    localparam int TIMER_W = 16;
    localparam int CNV_CYC = 4;
    localparam int RX_CYC  = 30;

    logic clk = 1'b0;
    logic rst, enable, mode, sync_trig, clr_err;
    logic [TIMER_W-1:0] period;
    logic [1:0]         avg_log2;
    logic [DATA_W-1:0]  out_x, out_y;
    logic               out_valid, busy, overrun, timeout_err;
    logic [15:0]        sample_count;

    eddy_current_sample_scheduler_if #(.DATA_W(DATA_W)) bus ();

    eddy_current_sample_scheduler #(
        .DATA_W(DATA_W), .TIMER_W(TIMER_W), .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .period(period),
        .avg_log2(avg_log2), .sync_trig(sync_trig), .clr_err(clr_err), .spi(bus),
        .out_x(out_x), .out_y(out_y), .out_valid(out_valid), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    // SPI master model: CNV (ready=1) then RX (ready=0); freezes while spi_en is low
    logic m_rdy;
    int   m_cnt, conv_n, base;
    logic hang;
    logic [7:0][DATA_W-1:0] xs, ys;

    assign bus.spi_data_ready = m_rdy;

    always @(posedge clk) begin
        if (rst) begin
            m_rdy <= 1'b1; m_cnt <= 0; conv_n <= 0;
            bus.spi_data_x <= '0; bus.spi_data_y <= '0;
        end else if (hang) begin
            m_rdy <= 1'b1; m_cnt <= 0;
        end else if (bus.spi_en) begin
            if (m_rdy) begin
                if (m_cnt == CNV_CYC - 1) begin m_rdy <= 1'b0; m_cnt <= 0; end
                else m_cnt <= m_cnt + 1;
            end else if (m_cnt == RX_CYC - 1) begin
                m_rdy <= 1'b1; m_cnt <= 0; conv_n <= conv_n + 1;
                bus.spi_data_x <= xs[3'(conv_n - base)];
                bus.spi_data_y <= ys[3'(conv_n - base)];
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Event monitor
    int   cyc = 0, ov_cnt = 0, or_cnt = 0, en_falls = 0, ov_last = 0, ov_prev = 0;
    logic en_d = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        en_d <= bus.spi_en;
        if (en_d && !bus.spi_en) en_falls <= en_falls + 1;
        if (overrun) or_cnt <= or_cnt + 1;
        if (out_valid) begin
            ov_cnt <= ov_cnt + 1; ov_prev <= ov_last; ov_last <= cyc;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_sync();
        @(negedge clk); sync_trig = 1'b1;
        cycles(2);      sync_trig = 1'b0;
    endtask

    task automatic wait_ov(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (ov_cnt < target && n < budget) begin @(negedge clk); n++; end
        ok = (ov_cnt >= target);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]             lg;
        logic [3:0][DATA_W-1:0] x;
        logic [3:0][DATA_W-1:0] y;
        logic [DATA_W-1:0]      ex;
        logic [DATA_W-1:0]      ey;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    task automatic set_vec(input int i, input logic [1:0] lg,
                           input int x0, input int x1, input int x2, input int x3,
                           input int y0, input int y1, input int y2, input int y3,
                           input int ex, input int ey);
        vecs[i].lg = lg;
        vecs[i].x  = {DATA_W'(x3), DATA_W'(x2), DATA_W'(x1), DATA_W'(x0)};
        vecs[i].y  = {DATA_W'(y3), DATA_W'(y2), DATA_W'(y1), DATA_W'(y0)};
        vecs[i].ex = DATA_W'(ex);
        vecs[i].ey = DATA_W'(ey);
    endtask

    initial begin
        bit ok;
        bit need_flush;
        int ov0, or0, fall0, k;

        set_vec(0, 2'd0, -1, 0, 0, 0,  1, 0, 0, 0,  -1, 1);
        set_vec(1, 2'd2, 4, 8, -4, -8,  1, 2, 3, 4,  0, 2);
        set_vec(2, 2'd2, 3, 3, 3, 4,  -1, -1, -1, -1,  3, -1);
        set_vec(3, 2'd1, -3, -4, 0, 0,  5, 6, 0, 0,  -4, 5);
        set_vec(4, 2'd3, 131071, 131071, 131071, 131071,
                -131072, -131072, -131072, -131072,  131071, -131072);
        set_vec(5, 2'd0, -131072, 0, 0, 0,  131071, 0, 0, 0,  -131072, 131071);

        rst = 1'b1; enable = 1'b0; mode = 1'b1; period = '0; avg_log2 = '0;
        sync_trig = 1'b0; clr_err = 1'b0; hang = 1'b0; base = 0;
        xs = '0; ys = '0;
        cycles(4);
        chk("rst spi_en", bus.spi_en, 0);
        chk("rst busy", busy, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst overrun", overrun, 0);
        chk("rst timeout_err", timeout_err, 0);
        chk("rst out_x", out_x, 0);
        chk("rst sample_count", sample_count, 0);
        rst = 1'b0;
        cycles(3);
        chk("idle spi_en", bus.spi_en, 0);
        enable = 1'b1;
        cycles(3);
        need_flush = 1'b1;

        for (int i = 0; i < NV; i++) begin
            for (int j = 0; j < 8; j++) begin
                xs[j] = vecs[i].x[j % 4];
                ys[j] = vecs[i].y[j % 4];
            end
            base = conv_n + (need_flush ? 1 : 0);
            need_flush = 1'b0;
            avg_log2 = vecs[i].lg;
            ov0 = ov_cnt; or0 = or_cnt; fall0 = en_falls;
            pulse_sync();
            wait_ov(ov0 + 1, 3000, ok);
            chk($sformatf("vec%0d result arrived", i), 32'(ok), 1);
            cycles(3);
            chk($sformatf("vec%0d out_x", i), out_x, vecs[i].ex);
            chk($sformatf("vec%0d out_y", i), out_y, vecs[i].ey);
            chk($sformatf("vec%0d one out_valid", i), ov_cnt - ov0, 1);
            chk($sformatf("vec%0d spi_en falls once", i), en_falls - fall0, 1);
            chk($sformatf("vec%0d no overrun", i), or_cnt - or0, 0);
            chk($sformatf("vec%0d busy low", i), busy, 0);
        end

        // External triggers every 20 clocks against a ~140-clock burst
        for (int j = 0; j < 8; j++) begin xs[j] = DATA_W'(10 * ((j % 4) + 1)); ys[j] = '0; end
        base = conv_n;
        avg_log2 = 2'd2;
        ov0 = ov_cnt; or0 = or_cnt;
        for (int p = 0; p < 5; p++) begin
            pulse_sync();
            cycles(17);
        end
        wait_ov(ov0 + 1, 3000, ok);
        chk("overrun result arrived", 32'(ok), 1);
        cycles(200);
        chk("overrun pulses", or_cnt - or0, 4);
        chk("overrun one result", ov_cnt - ov0, 1);
        chk("overrun out_x", out_x, 25);

        // Internal timer, period 1000
        for (int j = 0; j < 8; j++) begin xs[j] = 18'h1FFFF; ys[j] = 18'h00001; end
        avg_log2 = 2'd0;
        ov0 = ov_cnt; or0 = or_cnt;
        @(negedge clk); mode = 1'b0; period = 16'd1000;
        wait_ov(ov0 + 3, 5000, ok);
        period = '0;
        chk("timer results arrived", 32'(ok), 1);
        chk("timer interval", ov_last - ov_prev, 1000);
        chk("timer out_x", out_x, 18'h1FFFF);
        chk("timer out_y", out_y, 18'h00001);
        chk("timer no overrun", or_cnt - or0, 0);
        cycles(100);
        mode = 1'b1;
        cycles(3);

        // Stuck data_ready: conversion timeout
        hang = 1'b1;
        ov0 = ov_cnt;
        pulse_sync();
        k = 0;
        while (!bus.spi_en && k < 20) begin @(negedge clk); k++; end
        k = 0;
        while (!timeout_err && k < 400) begin @(negedge clk); k++; end
        chk("timeout latency", k, 255);
        cycles(5);
        chk("timeout sticky", timeout_err, 1);
        chk("timeout spi_en low", bus.spi_en, 0);
        chk("timeout busy low", busy, 0);
        chk("timeout no out_valid", ov_cnt - ov0, 0);
        hang = 1'b0;
        clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        chk("clr_err clears", timeout_err, 0);

        xs = '0; ys = '0;
        xs[7] = 18'h00ABC; xs[0] = 18'h00123; ys[0] = 18'h3FFFE;
        base = conv_n + 1;
        ov0 = ov_cnt;
        pulse_sync();
        wait_ov(ov0 + 1, 3000, ok);
        chk("post-timeout result", 32'(ok), 1);
        chk("post-timeout flush out_x", out_x, 18'h00123);
        chk("post-timeout out_y", out_y, 18'h3FFFE);

        // Enable dropped while the master is shifting
        xs[7] = 18'h00777; xs[0] = 18'h00055;
        ov0 = ov_cnt;
        pulse_sync();
        k = 0;
        while (m_rdy && k < 100) begin @(negedge clk); k++; end
        chk("enable test reached RX", 32'(m_rdy), 0);
        cycles(5);
        enable = 1'b0;
        cycles(3);
        chk("disable spi_en low", bus.spi_en, 0);
        chk("disable busy low", busy, 0);
        chk("disable no out_valid", ov_cnt - ov0, 0);
        enable = 1'b1;
        cycles(3);
        base = conv_n + 1;
        pulse_sync();
        wait_ov(ov0 + 1, 3000, ok);
        chk("re-enable result", 32'(ok), 1);
        chk("re-enable flush out_x", out_x, 18'h00055);
        chk("re-enable one result", ov_cnt - ov0, 1);

`ifdef ECS_SAMPLE_COUNTER_EN
        chk("sample_count", sample_count, 16'(ov_cnt));
`else
        chk("sample_count", sample_count, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eddy_current_sample_scheduler.md
# eddy_current_sample_scheduler

Sequences the eddy-current sensor SPI master: gates its enable, starts conversion bursts from a free-running timer or an external PWM-synchronous trigger, and detects completion from the master's `data_ready`. Captures the X/Y words, averages a power-of-two burst, and presents one signed result per trigger to the AXI register/interrupt logic. Sits between the register file and the SPI master, in the same clock domain as both.

## Interface
- `DATA_W`, 18, sensor word width (two's complement)
- `TIMER_W`, 16, period timer width
- `TIMEOUT_CYCLES`, 255, max clocks per conversion before abort
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `enable`  in  1  block enable; low aborts any burst
- `mode`  in  1  0 = internal timer trigger, 1 = `sync_trig` rising edge
- `period`  in  TIMER_W  timer trigger period in clocks; 0 disables timer triggers
- `avg_log2`  in  2  burst length = 2^avg_log2 (1, 2, 4, 8)
- `sync_trig`  in  1  external trigger (PWM carrier event)
- `clr_err`  in  1  clears `timeout_err`
- `spi_en`  out  1  drives SPI master `trig` (enable level)
- `spi_data_ready`  in  1  SPI master `data_ready`
- `spi_data_x`, `spi_data_y`  in  DATA_W  SPI master `sensor_data_x/y`
- `out_x`, `out_y`  out  DATA_W  averaged signed result
- `out_valid`  out  1  one-cycle pulse, new result
- `busy`  out  1  burst in progress
- `overrun`  out  1  one-cycle pulse, trigger dropped while busy
- `timeout_err`  out  1  sticky conversion-timeout flag
- `sample_count`  out  16  results produced (see Configuration)

## Operation
- Reset: all outputs 0, state IDLE, accumulators 0, timer 0, flush flag set.
- States: IDLE → ARM → WAIT_RX → WAIT_DONE → (WAIT_RX | OUTPUT) → ARM.
- IDLE: `spi_en`=0; go ARM when `enable`=1.
- ARM: wait for trigger; on trigger latch `avg_log2`, clear accumulators and sample index, go WAIT_RX.
- Trigger: mode 0 — timer counts 0..`period`-1 while `enable`, pulses at `period`-1 and wraps to 0; mode 1 — registered rising edge of `sync_trig`. Triggers outside ARM pulse `overrun` and are dropped.
- WAIT_RX: `spi_en`=1; wait for `spi_data_ready`=0 (master left CNV, shifting).
- WAIT_DONE: `spi_en`=1; on `spi_data_ready`=1 the master is back in CNV and `spi_data_x/y` hold the completed word: sign-extend and add into 21-bit accumulators, increment index. If index = 2^avg_log2 go OUTPUT, else WAIT_RX.
- Flush: set by reset and any abort; the first completed conversion after a flush is discarded (not accumulated, not counted), flag then cleared. Covers a master frozen mid-RX.
- OUTPUT: `spi_en`=0; `out_x/out_y` = accumulator >>> avg_log2 (arithmetic), low DATA_W bits; `out_valid` pulses; go ARM.
- Timeout: cycle counter cleared on entering WAIT_RX; if it reaches `TIMEOUT_CYCLES` in WAIT_RX/WAIT_DONE: set `timeout_err`, drop burst, set flush, go ARM. `clr_err` and a same-cycle timeout: set wins.
- `enable` low in any state: next state IDLE, `spi_en` low next cycle, burst discarded, flush set, no `out_valid`.
- `busy` = 1 in WAIT_RX, WAIT_DONE, OUTPUT.

## Timing
- All outputs registered.
- External trigger: `sync_trig` rising edge sampled at edge N → ARM exits at N+2; `spi_en` high from N+2.
- `spi_en` stays high continuously across a burst; falls the cycle after the final `spi_data_ready`=1 is sampled.
- `out_valid` high for exactly one cycle, 2 cycles after the final `spi_data_ready`=1 sample; `out_x/out_y` stable until next `out_valid`.
- Back-to-back: next trigger accepted the cycle after `out_valid`.
- Changing `period` mid-count takes effect at next wrap; a new value ≤ current count wraps at the next cycle.

## Configuration
- `ECS_SAMPLE_COUNTER_EN` defined: `sample_count` increments on every `out_valid`, wraps 0xFFFF→0, cleared by `rst`.
- Not defined: counter not built, `sample_count` tied to 0.

## Test plan
- Timer mode, period=1000, avg_log2=0, SPI model returns X=0x1FFFF, Y=0x00001 → `out_valid` every 1000 clocks, `out_x`=0x1FFFF, `out_y`=0x00001, no `overrun`.
- avg_log2=2, X samples 4, 8, −4, −8 (18-bit) → one `out_valid`, `out_x`=0; X samples 3,3,3,4 → `out_x`=3; `spi_en` never drops within burst.
- Mode 1, `sync_trig` pulses 20 clocks apart while a burst needs ~150 → `overrun` pulse per extra edge, one result per accepted trigger.
- SPI model holds `data_ready` high forever → `timeout_err`=1 after 255 clocks in WAIT_RX, no `out_valid`; `clr_err` clears it; next conversion discarded (flush).
- `enable` dropped mid-RX then re-raised, avg_log2=0 → first completed conversion discarded, second produces `out_valid`.
- With `ECS_SAMPLE_COUNTER_EN`, 65537 results → `sample_count`=1; without it → 0.
